hazard_scoreboard: RTL and testbench

Parametrised pipeline interlock for the 5-stage MIPS core, replacing fixed address-compare hazard detection with a per-register countdown scoreboard. It sits beside the ID stage: it records the result latency of every issued writer and stalls dependent instructions in ID until their operands can be forwarded. It also interlocks the multi-cycle multiply/divide unit (MDU), squashes the fetch slot on taken redirects, and counts stall cycles.

---
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown interlock for the ID stage.
// Each tracked GPR holds the number of cycles until its pending result can
// be forwarded to the ID comparator. ID stalls on a source whose count says
// the value is not ready yet. A separate counter interlocks the MDU. A
// saturating counter accumulates stall cycles.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 4,
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = $clog2(MAX_LAT + 1),
    parameter int MDU_W   = $clog2(MDU_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_branch,
    input  logic              id_wr_en,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic [LAT_W-1:0]  id_wr_lat,
    input  logic              id_mdu_start,
    input  logic              id_mdu_use,
    input  logic              id_redirect,
    output logic              pc_wre,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        hazard_cause,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Interlock state. Entry 0 exists only to keep indexing simple; it is
    // held at zero so r0 never produces a hazard.
    logic [LAT_W-1:0] cnt [NREG];
    logic [MDU_W-1:0] mdu_cnt;

    logic [LAT_W-1:0] rs_cnt;
    logic [LAT_W-1:0] rt_cnt;
    logic             rs_haz;
    logic             rt_haz;
    logic             data_haz;
    logic             mdu_haz;
    logic             stall;
    logic             issue;
    logic             wr_hit;
    logic [LAT_W-1:0] lat_clamped;

    // Source readiness: a branch needs the value now (count 0); other
    // instructions can take it from the forwarding path when count is 1.
    always_comb begin
        rs_cnt = cnt[id_rs_addr];
        rt_cnt = cnt[id_rt_addr];
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (id_rs_used && (id_rs_addr != '0)) begin
            rs_haz = id_is_branch ? (rs_cnt != '0) : (rs_cnt > LAT_W'(1));
        end
        if (id_rt_used && (id_rt_addr != '0)) begin
            rt_haz = id_is_branch ? (rt_cnt != '0) : (rt_cnt > LAT_W'(1));
        end
    end

    // Stall decision and pipeline control. A redirect raised while stalled
    // is dropped; the branch re-presents it when it finally issues.
    always_comb begin
        data_haz     = rs_haz | rt_haz;
        mdu_haz      = id_mdu_use & (mdu_cnt != '0);
        stall        = id_valid & (data_haz | mdu_haz);
        issue        = id_valid & ~stall;
        pc_wre       = ~stall;
        ifid_stall   = stall;
        idex_flush   = stall;
        ifid_flush   = ~stall & id_valid & id_redirect;
        hazard_cause = 2'd0;
        if (id_valid && data_haz) begin
            hazard_cause = 2'd1;
        end else if (id_valid && mdu_haz) begin
            hazard_cause = 2'd2;
        end
        mdu_busy     = (mdu_cnt != '0);
        wr_hit       = issue & id_wr_en & (id_wr_addr != '0);
        lat_clamped  = (id_wr_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_wr_lat;
    end

    // Register countdowns: a fresh issue loads the latency (newest writer
    // wins), otherwise nonzero counts drain by one every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (wr_hit && (id_wr_addr == ADDR_W'(r))) begin
                    cnt[r] <= lat_clamped;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // MDU countdown. The start cycle itself is the first busy cycle, so the
    // counter is loaded with one less than the busy length; a dependent
    // mfhi/mflo issued right behind the start then waits MDU_LAT-1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt <= '0;
        end else if (issue && id_mdu_start) begin
            mdu_cnt <= MDU_W'(MDU_LAT - 1);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one task per scenario, expected outputs are
// queued as each cycle's stimulus is applied and compared at the falling edge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_is_branch;
    logic       id_wr_en;
    logic [4:0] id_wr_addr;
    logic [2:0] id_wr_lat;
    logic       id_mdu_start;
    logic       id_mdu_use;
    logic       id_redirect;
    logic       pc_wre;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] hazard_cause;
    logic       mdu_busy;
    logic [2:0] stall_cnt;

    logic [9:0] obs;
    logic [9:0] want;
    logic [9:0] exp_q[$];
    int         checks;
    int         failures;
    int         sc_model;

    hazard_scoreboard #(
        .NREG(32), .ADDR_W(5), .MAX_LAT(4), .MDU_LAT(8), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_branch(id_is_branch), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_wr_lat(id_wr_lat),
        .id_mdu_start(id_mdu_start), .id_mdu_use(id_mdu_use),
        .id_redirect(id_redirect), .pc_wre(pc_wre), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .hazard_cause(hazard_cause), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    assign obs = {pc_wre, ifid_stall, ifid_flush, idex_flush, hazard_cause, mdu_busy, stall_cnt};

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word for one cycle
    function automatic logic [9:0] mk(input logic st, input logic fl, input logic [1:0] ca,
                                      input logic busy, input int sc);
        return {~st, st, fl, st, ca, busy, 3'(sc)};
    endfunction

    // Driver tasks
    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic br,
                         input logic wen, input logic [4:0] wa, input logic [2:0] lat,
                         input logic ms, input logic mu, input logic rd);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rs_used   = rsu;
        id_rt_addr   = rt;
        id_rt_used   = rtu;
        id_is_branch = br;
        id_wr_en     = wen;
        id_wr_addr   = wa;
        id_wr_lat    = lat;
        id_mdu_start = ms;
        id_mdu_use   = mu;
        id_redirect  = rd;
    endtask

    // Bubble with random don't-care fields; none of them may have any effect.
    task automatic idle();
        drive(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 3'd2, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 0));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL reset_redirect got=%b want=%b", obs, want);
        end
        idle();
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 0));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL reset_idle got=%b want=%b", obs, want);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sc_model = 0;
        for (int c = 0; c < 2; c++) begin
            idle();
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 0));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL post_reset c=%0d got=%b want=%b", c, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        logic st;
        logic fl;
        logic [1:0] ca;
        for (int c = 0; c < 4; c++) begin
            st = 1'b0; fl = 1'b0; ca = 2'd0;
            case (c)
                0: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 3'd2, 1'b0, 1'b0, 1'b0);
                1: begin
                    drive(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0);
                    st = 1'b1; ca = 2'd1;
                end
                2: drive(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0);
                default: idle();
            endcase
            exp_q.push_back(mk(st, fl, ca, 1'b0, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL load_use c=%0d got=%b want=%b", c, obs, want);
            end
            if (st && sc_model < 7) sc_model++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_branch();
        logic st;
        logic fl;
        logic [1:0] ca;
        for (int c = 0; c < 5; c++) begin
            st = 1'b0; fl = 1'b0; ca = 2'd0;
            case (c)
                0: drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 5'd9, 3'd2, 1'b0, 1'b0, 1'b0);
                1, 2: begin
                    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
                    st = 1'b1; ca = 2'd1;
                end
                3: begin
                    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
                    fl = 1'b1;
                end
                default: idle();
            endcase
            exp_q.push_back(mk(st, fl, ca, 1'b0, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL load_branch c=%0d got=%b want=%b", c, obs, want);
            end
            if (st && sc_model < 7) sc_model++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_r0();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 5'd0, 3'd4, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
                default: idle();
            endcase
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL r0_write c=%0d got=%b want=%b", c, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_waw();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0);
                2: drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd11, 3'd1, 1'b0, 1'b0, 1'b0);
                default: idle();
            endcase
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL waw c=%0d got=%b want=%b", c, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic st;
        logic fl;
        logic [1:0] ca;
        for (int c = 0; c < 10; c++) begin
            st = 1'b0; fl = 1'b0; ca = 2'd0;
            case (c)
                0: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd3, 3'd1, 1'b0, 1'b0, 1'b0);
                1: drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
                2: begin
                    drive(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
                    st = 1'b1; ca = 2'd1;
                end
                3: begin
                    drive(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
                    fl = 1'b1;
                end
                4: drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 5'd6, 3'd7, 1'b0, 1'b0, 1'b0);
                5, 6, 7: begin
                    drive(1'b1, 5'd6, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 5'd12, 3'd1, 1'b0, 1'b0, 1'b0);
                    st = 1'b1; ca = 2'd1;
                end
                8: drive(1'b1, 5'd6, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 5'd12, 3'd1, 1'b0, 1'b0, 1'b0);
                default: idle();
            endcase
            exp_q.push_back(mk(st, fl, ca, 1'b0, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%b want=%b", c, obs, want);
            end
            if (st && sc_model < 7) sc_model++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mdu();
        logic st;
        logic [1:0] ca;
        logic busy;
        for (int c = 0; c < 19; c++) begin
            st = 1'b0; ca = 2'd0;
            busy = ((c >= 1) && (c <= 7)) || ((c >= 10) && (c <= 16));
            case (c)
                0, 9: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0);
                1, 2, 3, 4, 5, 6, 7: begin
                    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 3'd1, 1'b0, 1'b1, 1'b0);
                    st = 1'b1; ca = 2'd2;
                end
                8: drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 3'd1, 1'b0, 1'b1, 1'b0);
                10: drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0, 1'b0);
                11: begin
                    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
                    st = 1'b1; ca = 2'd1;
                end
                12, 13, 14, 15, 16: begin
                    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
                    st = 1'b1; ca = 2'd2;
                end
                17: drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
                default: idle();
            endcase
            exp_q.push_back(mk(st, 1'b0, ca, busy, sc_model));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL mdu c=%0d got=%b want=%b", c, obs, want);
            end
            if (st && sc_model < 7) sc_model++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 5'd9, 3'd2, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, sc_model));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL mid_load got=%b want=%b", obs, want);
        end
        @(posedge clk);
        #1;
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, sc_model));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL mid_stall got=%b want=%b", obs, want);
        end
        // Reset lands in the middle of the stalled cycle.
        rst = 1'b1;
        sc_model = 0;
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 0));
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL mid_reset got=%b want=%b", obs, want);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 0));
            end else begin
                idle();
                exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 0));
            end
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL after_reset c=%0d got=%b want=%b", c, obs, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sc_model = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_r0();
        test_waw();
        test_back_to_back();
        test_mdu();
        test_reset_mid_stall();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
